univ_reg_cell: RTL

Parametrised universal register cell for Wokwi-mapped designs: a WIDTH-bit register with hold, parallel load, bidirectional shift, up/down count, and synchronous clear/set selected per cycle by a mode code. It generalises the single-bit flip-flop cells to a multi-bit primitive, so shift chains, counters and loadable registers are instantiated as one cell instead of hand-wired DFFs and muxes. It sits in the cell library beside the gate and flip-flop cells.

---
 rtl/univ_reg_pkg.sv | 16 +
 rtl/univ_reg_cell_if.sv | 29 ++
 rtl/univ_reg_next.sv | 56 +++++
 rtl/univ_reg_cell.sv | 51 +++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// Shared mode encoding for the universal register cell and anything that drives it.
package univ_reg_pkg;

  localparam int MODE_W = 3;
  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_INC  = 3'd4;
  localparam mode_t MODE_DEC  = 3'd5;
  localparam mode_t MODE_CLR  = 3'd6;
  localparam mode_t MODE_SET  = 3'd7;

endpackage

// File: rtl/univ_reg_cell_if.sv
// Control/data bundle of one universal register cell; the driver uses master,
// the cell uses slave.
interface univ_reg_cell_if #(
  parameter int WIDTH = 8
);
  import univ_reg_pkg::*;

  logic             ena;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] notq;
  logic             sout_l;
  logic             sout_r;
  logic             tc;

  modport master (
    output ena, mode, d, sin_r, sin_l,
    input  q, notq, sout_l, sout_r, tc
  );

  modport slave (
    input  ena, mode, d, sin_r, sin_l,
    output q, notq, sout_l, sout_r, tc
  );

endinterface

// File: rtl/univ_reg_next.sv
// Next-state and terminal-count function of the universal register cell.
// Build option: UNIV_REG_CELL_SAT_EN makes INC/DEC saturate instead of wrapping.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max;
  logic at_min;

  assign at_max = (q == ONES);
  assign at_min = (q == '0);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_next = q;
    tc     = 1'b0;
    case (mode)
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_INC: begin
        tc = at_max;
`ifdef UNIV_REG_CELL_SAT_EN
        if (!at_max) q_next = q + ONE;
`else
        q_next = q + ONE;
`endif
      end
      MODE_DEC: begin
        tc = at_min;
`ifdef UNIV_REG_CELL_SAT_EN
        if (!at_min) q_next = q - ONE;
`else
        q_next = q - ONE;
`endif
      end
      MODE_CLR:  q_next = '0;
      MODE_SET:  q_next = ONES;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_reg_cell.sv
// Universal WIDTH-bit register cell: hold/load/shift/count/clear/set per cycle.
// Build option: UNIV_REG_CELL_SAT_EN (saturating INC/DEC, handled in univ_reg_next).
module univ_reg_cell
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic           clk,
  input logic           rst_n,
  univ_reg_cell_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("univ_reg_cell: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             tc;

  univ_reg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode   (bus.mode),
    .q      (q_r),
    .d      (bus.d),
    .sin_l  (bus.sin_l),
    .sin_r  (bus.sin_r),
    .q_next (q_next),
    .tc     (tc)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, which is what makes chained cells shift in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= RESET_VALUE;
    end else if (bus.ena) begin
      q_r <= q_next;
    end
  end

  // tc is deliberately not gated by ena so a stalled counter still flags wrap.
  assign bus.q      = q_r;
  assign bus.notq   = ~q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.tc     = tc;

endmodule
